// File: rtl/tspi_target.sv
// TSPI (SPI mode 0) target bridging serial read/write commands to a byte-wide
// memory port; all wire inputs are oversampled by clk_i through synchronizers.
module tspi_target #(
  parameter int AddrWidth  = 24,
  parameter int SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tspi_clk_i,
  input  logic                 tspi_cs_ni,
  input  logic                 tspi_mosi_i,
  output logic                 tspi_miso_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [7:0]           mem_wdata_o,
  input  logic [7:0]           mem_rdata_i,
  output logic                 busy_o,
  output logic                 cmd_err_o
);

  localparam int CntW = (AddrWidth > 8) ? $clog2(AddrWidth) : 3;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  logic [SyncStages-1:0] sck_sync_reg;
  logic [SyncStages-1:0] cs_sync_reg;
  logic [SyncStages-1:0] mosi_sync_reg;

  generate
    for (genvar gi = 0; gi < SyncStages; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            sck_sync_reg[gi]  <= 1'b0;
            cs_sync_reg[gi]   <= 1'b1;
            mosi_sync_reg[gi] <= 1'b0;
          end else begin
            sck_sync_reg[gi]  <= tspi_clk_i;
            cs_sync_reg[gi]   <= tspi_cs_ni;
            mosi_sync_reg[gi] <= tspi_mosi_i;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            sck_sync_reg[gi]  <= 1'b0;
            cs_sync_reg[gi]   <= 1'b1;
            mosi_sync_reg[gi] <= 1'b0;
          end else begin
            sck_sync_reg[gi]  <= sck_sync_reg[gi-1];
            cs_sync_reg[gi]   <= cs_sync_reg[gi-1];
            mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic sck_s, cs_s, mosi_s;
  logic sck_q_reg, cs_q_reg;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_s  = sck_sync_reg[SyncStages-1];
  assign cs_s   = cs_sync_reg[SyncStages-1];
  assign mosi_s = mosi_sync_reg[SyncStages-1];

  // SCK edges only count while the target is selected.
  assign sck_rise = sck_s & ~sck_q_reg & ~cs_s;
  assign sck_fall = ~sck_s & sck_q_reg & ~cs_s;
  assign cs_fall  = ~cs_s & cs_q_reg;
  assign cs_rise  = cs_s & ~cs_q_reg;

  state_t               state_reg;
  logic [CntW-1:0]      bit_cnt_reg;
  logic [7:0]           shift_reg;
  logic [AddrWidth-1:0] addr_reg;
  logic                 is_read_reg;
  logic                 hold_reg;
  logic                 rd_wait_reg;
  logic [7:0]           data_out_reg;
  logic                 mem_req_reg, mem_we_reg, busy_reg, cmd_err_reg;
  logic [AddrWidth-1:0] mem_addr_reg;
  logic [7:0]           mem_wdata_reg;

  logic [7:0]           byte_next;
  logic [AddrWidth-1:0] addr_next;

  assign byte_next = {shift_reg[6:0], mosi_s};
  assign addr_next = {addr_reg[AddrWidth-2:0], mosi_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      sck_q_reg     <= 1'b0;
      cs_q_reg      <= 1'b1;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      addr_reg      <= '0;
      is_read_reg   <= 1'b0;
      hold_reg      <= 1'b0;
      rd_wait_reg   <= 1'b0;
      data_out_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      cmd_err_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      sck_q_reg   <= sck_s;
      cs_q_reg    <= cs_s;
      mem_req_reg <= 1'b0;
      mem_we_reg  <= 1'b0;
      cmd_err_reg <= 1'b0;
      // Read data arrives the cycle after the strobe cycle.
      rd_wait_reg <= mem_req_reg & ~mem_we_reg;

      if (cs_rise) begin
        state_reg    <= IDLE;
        busy_reg     <= 1'b0;
        data_out_reg <= '0;
        rd_wait_reg  <= 1'b0;
        hold_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cs_fall) begin
              state_reg   <= CMD;
              busy_reg    <= 1'b1;
              bit_cnt_reg <= '0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              shift_reg   <= byte_next;
              bit_cnt_reg <= bit_cnt_reg + CntW'(1);
              if (bit_cnt_reg == CntW'(7)) begin
                bit_cnt_reg <= '0;
                case (byte_next)
                  8'h03: begin state_reg <= ADDR; is_read_reg <= 1'b1; end
                  8'h02: begin state_reg <= ADDR; is_read_reg <= 1'b0; end
                  default: begin state_reg <= IGNORE; cmd_err_reg <= 1'b1; end
                endcase
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              addr_reg    <= addr_next;
              bit_cnt_reg <= bit_cnt_reg + CntW'(1);
              if (bit_cnt_reg == CntW'(AddrWidth - 1)) begin
                bit_cnt_reg <= '0;
                if (is_read_reg) begin
                  state_reg    <= READ;
                  mem_req_reg  <= 1'b1;
                  mem_addr_reg <= addr_next;
                  addr_reg     <= addr_next + AddrWidth'(1);
                  hold_reg     <= 1'b1;
                end else begin
                  state_reg <= WRITE;
                end
              end
            end
          end
          READ: begin
            if (sck_rise) begin
              bit_cnt_reg <= bit_cnt_reg + CntW'(1);
              if (bit_cnt_reg == CntW'(7)) begin
                bit_cnt_reg  <= '0;
                mem_req_reg  <= 1'b1;
                mem_addr_reg <= addr_reg;
                addr_reg     <= addr_reg + AddrWidth'(1);
                hold_reg     <= 1'b1;
              end
            end else if (sck_fall) begin
              if (hold_reg) hold_reg <= 1'b0;
              else          data_out_reg <= {data_out_reg[6:0], 1'b0};
            end
          end
          WRITE: begin
            if (sck_rise) begin
              shift_reg   <= byte_next;
              bit_cnt_reg <= bit_cnt_reg + CntW'(1);
              if (bit_cnt_reg == CntW'(7)) begin
                bit_cnt_reg   <= '0;
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= 1'b1;
                mem_wdata_reg <= byte_next;
                mem_addr_reg  <= addr_reg;
                addr_reg      <= addr_reg + AddrWidth'(1);
              end
            end
          end
          default: ;
        endcase

        if (rd_wait_reg && state_reg == READ) data_out_reg <= mem_rdata_i;
      end
    end
  end

  assign tspi_miso_o = data_out_reg[7];
  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign busy_o      = busy_reg;
  assign cmd_err_o   = cmd_err_reg;

endmodule

// File: tb/tb_tspi_target.sv
// Directed bench for tspi_target: a byte memory model answers strobes and
// logs every access so each scenario can check addresses, data and counts.
module tb_tspi_target;

  logic        clk = 1'b0;
  logic        rst, sck, cs_n, mosi;
  logic        miso, mem_req, mem_we, busy, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [256];
  logic [23:0] log_addr [64];
  logic        log_we   [64];
  logic [7:0]  log_data [64];
  int          log_n;
  int          err_n;
  int          req_snap;

  tspi_target #(.AddrWidth(24), .SyncStages(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tspi_clk_i  (sck),
    .tspi_cs_ni  (cs_n),
    .tspi_mosi_i (mosi),
    .tspi_miso_o (miso),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .cmd_err_o   (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      log_n     <= 0;
      err_n     <= 0;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_req) begin
        if (log_n < 64) begin
          log_addr[log_n] <= mem_addr;
          log_we[log_n]   <= mem_we;
          log_data[log_n] <= mem_we ? mem_wdata : mem[mem_addr[7:0]];
          log_n           <= log_n + 1;
        end
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr[7:0]];
      end
      if (cmd_err) err_n <= err_n + 1;
    end
  end

  // Half SCK period is six clk cycles; MISO is sampled just before each rise.
  task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (6) @(negedge clk);
      r[i] = miso;
      if (i == 0) req_snap = log_n;
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    logic [31:0] rr;
    send_bits({24'h0, b}, 8, rr);
    r = rr[7:0];
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write2(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0]  r;
    logic [31:0] rr;
    cs_low();
    send_byte(8'h02, r);
    send_bits({8'h0, a}, 24, rr);
    send_byte(d0, r);
    send_byte(d1, r);
    cs_high();
    $display("[TB] write addr=%06h data=%02h %02h", a, d0, d1);
  endtask

  task automatic do_read(input logic [23:0] a, input int nbytes,
                         output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0]  r;
    logic [31:0] rr;
    cs_low();
    send_byte(8'h03, r);
    send_bits({8'h0, a}, 24, rr);
    send_byte(8'h00, r0);
    r1 = 8'h00;
    if (nbytes > 1) send_byte(8'h00, r1);
    cs_high();
    $display("[TB] read addr=%06h bytes=%0d got %02h %02h", a, nbytes, r0, r1);
  endtask

  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (miso !== 1'b0)      begin fails++; $display("FAIL reset_miso got %b need 0", miso); end
    tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL reset_req got %b need 0", mem_req); end
    tests++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL reset_we got %b need 0", mem_we); end
    tests++; if (mem_addr !== 24'h0) begin fails++; $display("FAIL reset_addr got %h need 0", mem_addr); end
    tests++; if (mem_wdata !== 8'h0) begin fails++; $display("FAIL reset_wdata got %h need 0", mem_wdata); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b need 0", busy); end
    tests++; if (cmd_err !== 1'b0)   begin fails++; $display("FAIL reset_cmd_err got %b need 0", cmd_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] reset done");
  endtask

  task automatic test_write();
    int base = log_n;
    logic [7:0]  r;
    logic [31:0] rr;
    cs_low();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy got %b need 1", busy); end
    send_byte(8'h02, r);
    send_bits(32'h000010, 24, rr);
    send_byte(8'hA5, r);
    send_byte(8'h3C, r);
    cs_high();
    $display("[TB] write addr=000010 data=a5 3c");
    tests++; if (log_n - base != 2) begin fails++; $display("FAIL write_count got %0d need 2", log_n - base); end
    tests++; if (log_addr[base] !== 24'h000010 || log_we[base] !== 1'b1 || log_data[base] !== 8'hA5)
      begin fails++; $display("FAIL write_first got %h/%b/%h need 000010/1/a5", log_addr[base], log_we[base], log_data[base]); end
    tests++; if (log_addr[base+1] !== 24'h000011 || log_we[base+1] !== 1'b1 || log_data[base+1] !== 8'h3C)
      begin fails++; $display("FAIL write_second got %h/%b/%h need 000011/1/3c", log_addr[base+1], log_we[base+1], log_data[base+1]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_end got %b need 0", busy); end
  endtask

  task automatic test_read();
    int base = log_n;
    logic [7:0] r0, r1;
    do_read(24'h000010, 2, r0, r1);
    tests++; if (r0 !== 8'hA5) begin fails++; $display("FAIL read_byte0 got %h need a5", r0); end
    tests++; if (r1 !== 8'h3C) begin fails++; $display("FAIL read_byte1 got %h need 3c", r1); end
    tests++; if (req_snap - base != 2) begin fails++; $display("FAIL read_strobes got %0d need 2", req_snap - base); end
    tests++; if (log_addr[base] !== 24'h000010 || log_we[base] !== 1'b0)
      begin fails++; $display("FAIL read_addr0 got %h/%b need 000010/0", log_addr[base], log_we[base]); end
    tests++; if (log_addr[base+1] !== 24'h000011 || log_we[base+1] !== 1'b0)
      begin fails++; $display("FAIL read_addr1 got %h/%b need 000011/0", log_addr[base+1], log_we[base+1]); end
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL read_miso_idle got %b need 0", miso); end
  endtask

  task automatic test_wrap();
    int base = log_n;
    logic [7:0] r0, r1;
    do_write2(24'hFFFFFF, 8'h5A, 8'hC3);
    tests++; if (log_addr[base] !== 24'hFFFFFF || log_addr[base+1] !== 24'h000000)
      begin fails++; $display("FAIL wrap_write_addr got %h %h need ffffff 000000", log_addr[base], log_addr[base+1]); end
    base = log_n;
    do_read(24'hFFFFFF, 2, r0, r1);
    tests++; if (log_addr[base] !== 24'hFFFFFF || log_addr[base+1] !== 24'h000000)
      begin fails++; $display("FAIL wrap_read_addr got %h %h need ffffff 000000", log_addr[base], log_addr[base+1]); end
    tests++; if (r0 !== 8'h5A || r1 !== 8'hC3)
      begin fails++; $display("FAIL wrap_read_data got %h %h need 5a c3", r0, r1); end
  endtask

  task automatic test_bad_cmd();
    int base = log_n;
    int e0   = err_n;
    logic [7:0] r, r0, r1;
    cs_low();
    send_byte(8'h9F, r);
    send_byte(8'h03, r);
    send_byte(8'h00, r);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL badcmd_busy got %b need 1", busy); end
    cs_high();
    $display("[TB] command 9f sent");
    tests++; if (err_n - e0 != 1) begin fails++; $display("FAIL badcmd_err_pulses got %0d need 1", err_n - e0); end
    tests++; if (log_n - base != 0) begin fails++; $display("FAIL badcmd_no_access got %0d need 0", log_n - base); end
    base = log_n;
    do_read(24'h000010, 1, r0, r1);
    tests++; if (r0 !== 8'hA5 || log_addr[base] !== 24'h000010)
      begin fails++; $display("FAIL badcmd_followup got %h@%h need a5@000010", r0, log_addr[base]); end
  endtask

  task automatic test_abort();
    int base = log_n;
    int n;
    logic [7:0]  r;
    logic [31:0] rr;
    cs_low();
    send_byte(8'h02, r);
    send_bits(32'h000020, 24, rr);
    send_bits(32'h16, 5, rr);
    @(negedge clk);
    cs_n = 1'b1;
    n = 11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin n = i; break; end
    end
    $display("[TB] write aborted after 5 bits, busy low after %0d cycles", n);
    tests++; if (n > 3) begin fails++; $display("FAIL abort_busy_cycles got %0d need <= 3", n); end
    repeat (8) @(negedge clk);
    tests++; if (log_n - base != 0) begin fails++; $display("FAIL abort_no_write got %0d need 0", log_n - base); end
  endtask

  task automatic test_rst_mid();
    int base;
    logic [7:0]  r;
    logic [31:0] rr;
    cs_low();
    send_byte(8'h03, r);
    send_bits(32'hABC, 12, rr);
    rst = 1'b1;
    cs_n = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rstmid_busy got %b need 0", busy); end
    tests++; if (mem_addr !== 24'h0) begin fails++; $display("FAIL rstmid_addr got %h need 0", mem_addr); end
    tests++; if (mem_wdata !== 8'h0) begin fails++; $display("FAIL rstmid_wdata got %h need 0", mem_wdata); end
    tests++; if ({miso, mem_req, mem_we, cmd_err} !== 4'b0)
      begin fails++; $display("FAIL rstmid_strobes got %b need 0000", {miso, mem_req, mem_we, cmd_err}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    base = log_n;
    cs_low();
    send_byte(8'h02, r);
    send_bits(32'h000030, 24, rr);
    send_byte(8'h77, r);
    cs_high();
    $display("[TB] write after reset addr=000030 data=77");
    tests++; if (log_n - base != 1 || log_addr[base] !== 24'h000030 || log_we[base] !== 1'b1 || log_data[base] !== 8'h77)
      begin fails++; $display("FAIL rstmid_next got n=%0d %h/%b/%h need n=1 000030/1/77",
                              log_n - base, log_addr[base], log_we[base], log_data[base]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout got running need finished");
    $fatal(1, "timeout");
  end

endmodule
